insert_sort_job_arbiter: RTL
============================

# insert_sort_job_arbiter

Round-robin job scheduler that shares one `ap_ctrl_hs` sort kernel (the `insert_sort_function` top) between `NREQ` requesters. It drives the kernel's `ap_start`, tracks `ap_ready`/`ap_done`, and steers the argument/result mux through `sel`. It returns per-requester ack/done/error pulses and recovers from a hung kernel with a watchdog. It also keeps job and busy-cycle counters for the same status dumps the dataflow monitors produce.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..16).
- `TO_W`, 16: watchdog limit width.
- `CNT_W`, 32: statistics counter width.

Ports:
- `ap_clk` in 1: clock.
- `ap_rst_n` in 1: asynchronous active-low reset; same net resets the kernel.
- `req` in `NREQ`: level request per requester; held until `ack`.
- `ack` out `NREQ`: one-hot, 1-cycle pulse when the kernel accepts that requester's job.
- `done` out `NREQ`: one-hot, 1-cycle pulse when that job finishes.
- `err` out `NREQ`: one-hot, 1-cycle pulse when that job times out.
- `sel` out `$clog2(NREQ)`: granted requester index; stable from grant until return to IDLE.
- `busy` out 1: high in every state except IDLE.
- `k_ap_start` out 1: kernel start.
- `k_ap_ready` in 1: kernel ready.
- `k_ap_done` in 1: kernel done.
- `k_ap_idle` in 1: kernel idle.
- `to_lim` in `TO_W`: watchdog limit in cycles; 0 disables the watchdog.
- `job_cnt` out `CNT_W`: completed jobs; wraps.
- `busy_cyc` out `CNT_W`: cycles spent with `busy` high; saturates at all-ones.

## Operation
- The FSM has five states: IDLE, START, RUN, DONE, FLUSH.
- IDLE:
  - If `req` is nonzero, grant the first set bit at or after `ptr` (search wraps), latch `sel`, and go to START.
  - `ptr` resets to 0.
- START:
  - `k_ap_start` = 1.
  - When `k_ap_ready` = 1: pulse `ack[sel]`, drop `k_ap_start` from the next cycle, and go to RUN.
  - If `k_ap_done` = 1 in the same cycle, go directly to DONE.
- RUN: wait for `k_ap_done` = 1, then go to DONE.
- DONE (one cycle):
  - Pulse `done[sel]`.
  - `job_cnt` += 1, wrapping modulo 2^`CNT_W`.
  - `ptr` = `sel`+1 mod `NREQ`.
  - Go to IDLE.
- Watchdog:
  - The counter clears on entry to START and counts every cycle in START or RUN.
  - If `to_lim` != 0 and the count reaches `to_lim`: pulse `err[sel]`, drop `k_ap_start`, set `ptr` = `sel`+1, and go to FLUSH.
  - `job_cnt` is not incremented on a timeout.
- FLUSH:
  - Wait for `k_ap_idle` = 1, then go to IDLE.
  - A `k_ap_done` seen in FLUSH is discarded; no `done` pulse.
- Request handling:
  - `req` bits are only sampled in IDLE.
  - Deasserting `req[sel]` after grant does not cancel the job; the job runs to DONE.
  - New requests arriving during a job wait for IDLE.
- `busy_cyc` increments every cycle `busy` = 1 and holds at 2^`CNT_W`-1.

## Timing
- Reset state (asynchronous): state = IDLE; `ptr` = 0; `sel`, `ack`, `done`, `err`, `k_ap_start`, `busy` = 0; `job_cnt` and `busy_cyc` = 0.
- Reset mid-job: outputs clear immediately; no `done`/`err` pulse for the aborted job.
- All outputs are registered.
- Grant latency: `req` sampled high at edge N gives `k_ap_start` = 1 and `busy` = 1 from cycle N+1.
- `ack` asserts the cycle after `k_ap_ready` is sampled. `k_ap_start` is 0 in that same cycle.
- `done` asserts the cycle after `k_ap_done` is sampled. IDLE follows, and the next grant is sampled at the edge after that.
- Back-to-back overhead: 2 idle cycles of `k_ap_start` between jobs (DONE and IDLE).
- Timeout: `err` asserts exactly `to_lim`+1 cycles after `k_ap_start` first rose.
- `to_lim` is sampled continuously. Lowering it below the current count forces an immediate timeout on the next edge.
- Pulses are mutually exclusive: at most one of `ack`, `done`, `err` bits is high in any cycle, except `ack` and `done` together when ready and done coincide.

## Test plan
- Single job: `req` = 0001, kernel ready after 1 cycle and done after 20 → `ack[0]` 1 pulse, `done[0]` 1 pulse, `job_cnt` = 1, `busy_cyc` = 23.
- Fairness: `req` = 1111 held, kernel latency 5 → `ack` order 0,1,2,3,0,…; after 8 jobs `job_cnt` = 8, with 2 jobs per requester.
- Zero-latency kernel: `k_ap_ready` and `k_ap_done` both high on the first START cycle → `ack` and `done` in the same cycle, DONE then IDLE, no hang.
- Timeout: `to_lim` = 10, kernel never asserts done → `err[sel]` 11 cycles after start; FLUSH holds until `k_ap_idle` = 1; `job_cnt` unchanged; next grant goes to `sel`+1.
- Async reset asserted in RUN with `sel` = 2 → all outputs 0 immediately; after release, `req` = 0100 grants requester 2 with `ptr` back at 0.
- Counter limits: with `CNT_W` = 4, run 17 jobs → `job_cnt` = 1 (wrapped) and `busy_cyc` = 15 (saturated).

Source files
------------

// File: rtl/insert_sort_job_arbiter.sv
// Round-robin scheduler sharing one ap_ctrl_hs sort kernel between NREQ requesters.
// Drives ap_start, steers the argument mux via sel, and flushes a hung kernel on watchdog expiry.
module insert_sort_job_arbiter #(
   parameter int  NREQ  = 4,
   parameter int  TO_W  = 16,
   parameter int  CNT_W = 32,
   localparam int SW    = $clog2(NREQ)
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   // Handshake: a requester holds req high until its ack pulse; from ack on the job belongs to
   // the arbiter and is closed by exactly one done or err pulse (none if reset aborts it).
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  ack,
   output logic [NREQ-1:0]  done,
   output logic [NREQ-1:0]  err,
   output logic [SW-1:0]    sel,
   output logic             busy,
   output logic             k_ap_start,
   input  logic             k_ap_ready,
   input  logic             k_ap_done,
   input  logic             k_ap_idle,
   input  logic [TO_W-1:0]  to_lim,
   output logic [CNT_W-1:0] job_cnt,
   output logic [CNT_W-1:0] busy_cyc,
   output logic [2:0]       o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_RUN   = 3'd2,
      S_DONE  = 3'd3,
      S_FLUSH = 3'd4
   } state_t;

   localparam logic [SW:0] NREQ_W = (SW + 1)'(NREQ);

   state_t           r_state;
   logic [SW-1:0]    r_ptr;
   logic [SW-1:0]    r_sel;
   logic [NREQ-1:0]  r_ack;
   logic [NREQ-1:0]  r_done;
   logic [NREQ-1:0]  r_err;
   logic             r_start;
   logic             r_busy;
   logic [TO_W-1:0]  r_wd;
   logic [CNT_W-1:0] r_job_cnt;
   logic [CNT_W-1:0] r_busy_cyc;

   logic [NREQ-1:0]  w_req_rot;
   logic [SW-1:0]    w_off;
   logic             w_gnt_vld;
   logic [SW:0]      w_sum;
   logic [SW-1:0]    w_gnt_idx;
   logic [SW-1:0]    w_sel_inc;
   logic [NREQ-1:0]  w_sel_oh;
   logic [TO_W-1:0]  w_wd_inc;
   logic             w_wd_hit;

   // Rotate so bit 0 is the requester at ptr; the lowest set bit is then the round-robin winner.
   assign w_req_rot = NREQ'({req, req} >> r_ptr);
   assign w_gnt_vld = |w_req_rot;

   always_comb begin
      w_off = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (w_req_rot[i]) w_off = SW'(i);
      end
   end

   assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
   assign w_gnt_idx = (w_sum >= NREQ_W) ? SW'(w_sum - NREQ_W) : SW'(w_sum);
   assign w_sel_inc = (r_sel == SW'(NREQ - 1)) ? '0 : r_sel + SW'(1);
   assign w_sel_oh  = NREQ'(1) << r_sel;
   assign w_wd_inc  = (r_wd == '1) ? r_wd : r_wd + TO_W'(1);
   // Compared with >= so that lowering to_lim below the running count expires at once.
   assign w_wd_hit  = (to_lim != '0) && (r_wd >= to_lim);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_sel     <= '0;
         r_ack     <= '0;
         r_done    <= '0;
         r_err     <= '0;
         r_start   <= 1'b0;
         r_busy    <= 1'b0;
         r_wd      <= '0;
         r_job_cnt <= '0;
      end else begin
         r_ack  <= '0;
         r_done <= '0;
         r_err  <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_gnt_vld) begin
                  r_sel   <= w_gnt_idx;
                  r_start <= 1'b1;
                  r_busy  <= 1'b1;
                  r_wd    <= '0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               r_wd <= w_wd_inc;
               if (k_ap_ready) begin
                  r_ack   <= w_sel_oh;
                  r_start <= 1'b0;
                  if (k_ap_done) begin
                     r_done    <= w_sel_oh;
                     r_job_cnt <= r_job_cnt + CNT_W'(1);
                     r_ptr     <= w_sel_inc;
                     r_state   <= S_DONE;
                  end else begin
                     r_state <= S_RUN;
                  end
               end else if (w_wd_hit) begin
                  r_err   <= w_sel_oh;
                  r_start <= 1'b0;
                  r_ptr   <= w_sel_inc;
                  r_state <= S_FLUSH;
               end
            end
            S_RUN: begin
               r_wd <= w_wd_inc;
               if (k_ap_done) begin
                  r_done    <= w_sel_oh;
                  r_job_cnt <= r_job_cnt + CNT_W'(1);
                  r_ptr     <= w_sel_inc;
                  r_state   <= S_DONE;
               end else if (w_wd_hit) begin
                  r_err   <= w_sel_oh;
                  r_ptr   <= w_sel_inc;
                  r_state <= S_FLUSH;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            S_FLUSH: begin
               // A late k_ap_done from the abandoned job is ignored here.
               if (k_ap_idle) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_start <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_busy_cyc <= '0;
      end else if (r_busy && (r_busy_cyc != '1)) begin
         r_busy_cyc <= r_busy_cyc + CNT_W'(1);
      end
   end

   assign ack         = r_ack;
   assign done        = r_done;
   assign err         = r_err;
   assign sel         = r_sel;
   assign busy        = r_busy;
   assign k_ap_start  = r_start;
   assign job_cnt     = r_job_cnt;
   assign busy_cyc    = r_busy_cyc;
   assign o_dbg_state = r_state;

endmodule
